tlb_op_ctrl: RTL and testbench

Sequencer for the LoongArch TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It accepts one op from the execute stage over a valid/ready handshake. It then drives the address-translation unit's TLB command ports for exactly one cycle, captures the returned result and writes it back to the TLB CSRs. On completion it raises done, and raises flush_req when the op altered TLB state.

---
 rtl/tlb_pkg.sv | 41 ++++
 rtl/tlb_rand_gen.sv | 32 +++
 rtl/tlb_op_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared op codes, FSM states and TLB CSR field layout for the TLB maintenance sequencer.
package tlb_pkg;

  localparam logic [2:0] TLBOP_SRCH = 3'd0;
  localparam logic [2:0] TLBOP_RD   = 3'd1;
  localparam logic [2:0] TLBOP_WR   = 3'd2;
  localparam logic [2:0] TLBOP_FILL = 3'd3;
  localparam logic [2:0] TLBOP_INV  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_WB    = 2'd3
  } tlb_state_e;

  // TLBIDX layout: NE at bit 31, PS in [29:24], INDEX in [IDX_W-1:0]
  localparam int CSR_NE_BIT = 31;
  localparam int CSR_PS_HI  = 29;
  localparam int CSR_PS_LO  = 24;

  localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

  function automatic logic op_legal(input logic [2:0] code, input logic [4:0] inv_op);
    return (code <= TLBOP_INV) && !((code == TLBOP_INV) && (inv_op > INVTLB_OP_MAX));
  endfunction

  // Fibonacci feedback masks for maximal-length LFSRs of width 2..8
  function automatic logic [7:0] lfsr_taps(input int width);
    case (width)
      2:       return 8'h03;
      3:       return 8'h06;
      4:       return 8'h0C;
      5:       return 8'h14;
      6:       return 8'h30;
      7:       return 8'h60;
      default: return 8'hB8;
    endcase
  endfunction

endpackage

// File: rtl/tlb_rand_gen.sv
// TLBFILL victim index: free-running counter, or a seed-1 maximal LFSR when TLB_RAND_LFSR_EN is defined.
// Advances every cycle with no stall input; the registered output is stable within each cycle.
module tlb_rand_gen
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [$clog2(TLBNUM)-1:0] rand_index
);

  localparam int W = $clog2(TLBNUM);

`ifdef TLB_RAND_LFSR_EN
  localparam logic [7:0]   TAPS_ALL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];

  // Seeded with 1 so the all-zero lock-up state is never reached
  always_ff @(posedge clk) begin
    if (!rst_n) rand_index <= W'(1);
    else        rand_index <= {rand_index[W-2:0], ^(rand_index & TAPS)};
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n)                            rand_index <= '0;
    else if (rand_index == W'(TLBNUM - 1)) rand_index <= '0;
    else                                   rand_index <= rand_index + 1'b1;
  end
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences one TLB maintenance op: IDLE -> ISSUE -> RESP -> WB, done 3 cycles after accept.
// op_ready is high only in IDLE; an op in flight ignores op_kill. Index source set by TLB_RAND_LFSR_EN.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 32,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic             op_kill,
  input  logic [4:0]       inv_op_in,
  input  logic [9:0]       inv_asid_in,
  input  logic [18:0]      inv_vpn_in,
  input  logic [31:0]      csr_tlbidx_in,
  output logic             tlbsrch_en,
  output logic             tlbwr_en,
  output logic             tlbfill_en,
  output logic             invtlb_en,
  output logic [IDX_W-1:0] rand_index,
  output logic [4:0]       invtlb_op,
  output logic [9:0]       invtlb_asid,
  output logic [18:0]      invtlb_vpn,
  input  logic             search_tlb_found,
  input  logic [IDX_W-1:0] search_tlb_index,
  input  logic [31:0]      tlbehi_rd,
  input  logic [31:0]      tlbelo0_rd,
  input  logic [31:0]      tlbelo1_rd,
  input  logic [31:0]      tlbidx_rd,
  input  logic [9:0]       asid_rd,
  output logic             csr_tlbidx_we,
  output logic             csr_tlbehi_we,
  output logic             csr_tlbelo0_we,
  output logic             csr_tlbelo1_we,
  output logic             csr_asid_we,
  output logic [31:0]      csr_tlbidx_wdata,
  output logic [31:0]      csr_tlbehi_wdata,
  output logic [31:0]      csr_tlbelo0_wdata,
  output logic [31:0]      csr_tlbelo1_wdata,
  output logic [9:0]       csr_asid_wdata,
  output logic             done,
  output logic             flush_req,
  output logic             ine_exc
);

  tlb_state_e       state_q, state_d;
  logic [2:0]       op_q;
  logic [30:0]      tlbidx_q;
  logic             found_q;
  logic [IDX_W-1:0] sidx_q;
  logic [31:0]      ehi_q, elo0_q, elo1_q, idx_rd_q;
  logic [9:0]       asid_rd_q;
  logic             accept, legal;

  assign op_ready = (state_q == ST_IDLE);
  assign accept   = op_valid && op_ready && !op_kill;
  assign legal    = op_legal(op_code, inv_op_in);

  tlb_rand_gen #(.TLBNUM(TLBNUM)) u_rand (
    .clk        (clk),
    .rst_n      (rst_n),
    .rand_index (rand_index)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= TLBOP_SRCH;
      tlbidx_q    <= '0;
      invtlb_op   <= '0;
      invtlb_asid <= '0;
      invtlb_vpn  <= '0;
      ine_exc     <= 1'b0;
      found_q     <= 1'b0;
      sidx_q      <= '0;
      ehi_q       <= '0;
      elo0_q      <= '0;
      elo1_q      <= '0;
      idx_rd_q    <= '0;
      asid_rd_q   <= '0;
    end else begin
      state_q <= state_d;
      ine_exc <= accept && !legal;
      if (accept && legal) begin
        op_q        <= op_code;
        tlbidx_q    <= csr_tlbidx_in[30:0];
        invtlb_op   <= inv_op_in;
        invtlb_asid <= inv_asid_in;
        invtlb_vpn  <= inv_vpn_in;
      end
      // ATU results are valid only in the cycle after the command strobe
      if (state_q == ST_RESP) begin
        found_q   <= search_tlb_found;
        sidx_q    <= search_tlb_index;
        ehi_q     <= tlbehi_rd;
        elo0_q    <= tlbelo0_rd;
        elo1_q    <= tlbelo1_rd;
        idx_rd_q  <= tlbidx_rd;
        asid_rd_q <= asid_rd;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    tlbsrch_en        = 1'b0;
    tlbwr_en          = 1'b0;
    tlbfill_en        = 1'b0;
    invtlb_en         = 1'b0;
    csr_tlbidx_we     = 1'b0;
    csr_tlbehi_we     = 1'b0;
    csr_tlbelo0_we    = 1'b0;
    csr_tlbelo1_we    = 1'b0;
    csr_asid_we       = 1'b0;
    csr_tlbidx_wdata  = '0;
    csr_tlbehi_wdata  = '0;
    csr_tlbelo0_wdata = '0;
    csr_tlbelo1_wdata = '0;
    csr_asid_wdata    = '0;
    done              = 1'b0;
    flush_req         = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept && legal) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_RESP;
        // TLBRD has no strobe: the ATU reads the entry named by TLBIDX directly
        case (op_q)
          TLBOP_SRCH: tlbsrch_en = 1'b1;
          TLBOP_WR:   tlbwr_en   = 1'b1;
          TLBOP_FILL: tlbfill_en = 1'b1;
          TLBOP_INV:  invtlb_en  = 1'b1;
          default:    ;
        endcase
      end
      ST_RESP:  state_d = ST_WB;
      ST_WB: begin
        state_d = ST_IDLE;
        done    = 1'b1;
        case (op_q)
          TLBOP_SRCH: begin
            csr_tlbidx_we = 1'b1;
            if (found_q) csr_tlbidx_wdata = {1'b0, tlbidx_q[30:IDX_W], sidx_q};
            else         csr_tlbidx_wdata = {1'b1, tlbidx_q};
          end
          TLBOP_RD: begin
            csr_tlbidx_we  = 1'b1;
            csr_tlbehi_we  = 1'b1;
            csr_tlbelo0_we = 1'b1;
            csr_tlbelo1_we = 1'b1;
            csr_asid_we    = 1'b1;
            if (idx_rd_q[CSR_NE_BIT]) begin
              csr_tlbidx_wdata = {1'b1, 1'b0, 6'b0, tlbidx_q[CSR_PS_LO-1:0]};
            end else begin
              csr_tlbidx_wdata  = idx_rd_q;
              csr_tlbehi_wdata  = ehi_q;
              csr_tlbelo0_wdata = elo0_q;
              csr_tlbelo1_wdata = elo1_q;
              csr_asid_wdata    = asid_rd_q;
            end
          end
          default: flush_req = 1'b1;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed plus random ops against a spec-level expectation model; rand_index model follows TLB_RAND_LFSR_EN.
module tb_tlb_op_ctrl;
    localparam int TLBNUM = 32;
    localparam int IDX_W  = 5;

    logic        clk, rst_n;
    logic        op_valid, op_ready, op_kill;
    logic [2:0]  op_code;
    logic [4:0]  inv_op_in;
    logic [9:0]  inv_asid_in;
    logic [18:0] inv_vpn_in;
    logic [31:0] csr_tlbidx_in;
    logic        tlbsrch_en, tlbwr_en, tlbfill_en, invtlb_en;
    logic [IDX_W-1:0] rand_index;
    logic [4:0]  invtlb_op;
    logic [9:0]  invtlb_asid;
    logic [18:0] invtlb_vpn;
    logic        search_tlb_found;
    logic [IDX_W-1:0] search_tlb_index;
    logic [31:0] tlbehi_rd, tlbelo0_rd, tlbelo1_rd, tlbidx_rd;
    logic [9:0]  asid_rd;
    logic        csr_tlbidx_we, csr_tlbehi_we, csr_tlbelo0_we, csr_tlbelo1_we, csr_asid_we;
    logic [31:0] csr_tlbidx_wdata, csr_tlbehi_wdata, csr_tlbelo0_wdata, csr_tlbelo1_wdata;
    logic [9:0]  csr_asid_wdata;
    logic        done, flush_req, ine_exc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lfsr_m  = 1;

    tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_kill(op_kill), .inv_op_in(inv_op_in), .inv_asid_in(inv_asid_in), .inv_vpn_in(inv_vpn_in),
        .csr_tlbidx_in(csr_tlbidx_in), .tlbsrch_en(tlbsrch_en), .tlbwr_en(tlbwr_en),
        .tlbfill_en(tlbfill_en), .invtlb_en(invtlb_en), .rand_index(rand_index),
        .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid), .invtlb_vpn(invtlb_vpn),
        .search_tlb_found(search_tlb_found), .search_tlb_index(search_tlb_index),
        .tlbehi_rd(tlbehi_rd), .tlbelo0_rd(tlbelo0_rd), .tlbelo1_rd(tlbelo1_rd),
        .tlbidx_rd(tlbidx_rd), .asid_rd(asid_rd), .csr_tlbidx_we(csr_tlbidx_we),
        .csr_tlbehi_we(csr_tlbehi_we), .csr_tlbelo0_we(csr_tlbelo0_we),
        .csr_tlbelo1_we(csr_tlbelo1_we), .csr_asid_we(csr_asid_we),
        .csr_tlbidx_wdata(csr_tlbidx_wdata), .csr_tlbehi_wdata(csr_tlbehi_wdata),
        .csr_tlbelo0_wdata(csr_tlbelo0_wdata), .csr_tlbelo1_wdata(csr_tlbelo1_wdata),
        .csr_asid_wdata(csr_asid_wdata), .done(done), .flush_req(flush_req), .ine_exc(ine_exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $error("FAIL watchdog: simulation did not finish within the time limit");
        $finish;
    end

    // Reference index source: cycles since reset release, or polynomial x^5+x^3+1 from seed 1
    always @(posedge clk) begin
        if (!rst_n) begin
            cyc    <= 0;
            lfsr_m <= 1;
        end else begin
            cyc    <= cyc + 1;
            lfsr_m <= ((lfsr_m * 2) % TLBNUM) + (((lfsr_m / 16) + (lfsr_m / 4)) % 2);
        end
    end

    function automatic logic [IDX_W-1:0] exp_rand();
`ifdef TLB_RAND_LFSR_EN
        return IDX_W'(lfsr_m);
`else
        return IDX_W'(cyc % TLBNUM);
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_resp();
        search_tlb_found = 1'($urandom);
        search_tlb_index = IDX_W'($urandom);
        tlbehi_rd  = $urandom;
        tlbelo0_rd = $urandom;
        tlbelo1_rd = $urandom;
        tlbidx_rd  = $urandom;
        asid_rd    = 10'($urandom);
    endtask

    task automatic run_op(input logic [2:0] code, input logic [4:0] iop, input logic [9:0] asid,
                          input logic [18:0] vpn, input logic [31:0] tin, input logic found,
                          input logic [4:0] sidx, input logic [31:0] ehi, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] irdv, input logic [9:0] ard,
                          input bit kacc, input bit kiss);
        bit          legal;
        bit          empty;
        logic [31:0] exp_idx;
        logic [3:0]  exp_strb;
        legal = (code <= 3'd4) && !(code == 3'd4 && iop > 5'd6);
        empty = irdv[31];
        exp_strb = {code == 3'd0, code == 3'd2, code == 3'd3, code == 3'd4};
        if (code == 3'd0) exp_idx = found ? ((tin & 32'h7FFF_FFE0) | 32'(sidx)) : (tin | 32'h8000_0000);
        else if (code == 3'd1) exp_idx = empty ? (32'h8000_0000 | (tin & 32'h00FF_FFFF)) : irdv;
        else exp_idx = 32'h0;

        chk("ready_idle", op_ready, 1'b1);
        op_valid = 1'b1; op_code = code; inv_op_in = iop; inv_asid_in = asid; inv_vpn_in = vpn;
        csr_tlbidx_in = tin; op_kill = kacc;
        step();
        op_valid = 1'b0; op_kill = 1'b0; op_code = 3'($urandom); inv_op_in = 5'($urandom);
        inv_asid_in = 10'($urandom); inv_vpn_in = 19'($urandom); csr_tlbidx_in = $urandom;
        if (kacc || !legal) begin
            chk("ine_exc", ine_exc, (!kacc && !legal));
            chk("no_strobe", {tlbsrch_en, tlbwr_en, tlbfill_en, invtlb_en}, 4'b0);
            chk("stay_idle", op_ready, 1'b1);
            step();
            chk("no_done", done, 1'b0);
            chk("ine_once", ine_exc, 1'b0);
            return;
        end
        // ISSUE
        chk("strobes", {tlbsrch_en, tlbwr_en, tlbfill_en, invtlb_en}, exp_strb);
        chk("busy", op_ready, 1'b0);
        chk("rand_index", rand_index, exp_rand());
`ifdef TLB_RAND_LFSR_EN
        chk("lfsr_nonzero", (rand_index != '0), 1'b1);
`endif
        if (code == 3'd4) chk("inv_fields", {invtlb_op, invtlb_asid, invtlb_vpn}, {iop, asid, vpn});
        op_valid = 1'b1; op_code = 3'($urandom_range(0, 4)); op_kill = kiss;
        step();
        // RESP
        chk("strobe_1cyc", {tlbsrch_en, tlbwr_en, tlbfill_en, invtlb_en}, 4'b0);
        chk("busy_resp", op_ready, 1'b0);
        op_kill = 1'b0;
        search_tlb_found = found; search_tlb_index = sidx; tlbehi_rd = ehi; tlbelo0_rd = e0;
        tlbelo1_rd = e1; tlbidx_rd = irdv; asid_rd = ard;
        step();
        // WB
        scramble_resp();
        op_valid = 1'b0;
        chk("done", done, 1'b1);
        chk("flush_req", flush_req, (code >= 3'd2));
        chk("we", {csr_tlbidx_we, csr_tlbehi_we, csr_tlbelo0_we, csr_tlbelo1_we, csr_asid_we},
            {code <= 3'd1, {4{code == 3'd1}}});
        if (code <= 3'd1) chk("tlbidx_wdata", csr_tlbidx_wdata, exp_idx);
        if (code == 3'd1) begin
            chk("ehi_wdata", csr_tlbehi_wdata, (empty ? 32'h0 : ehi));
            chk("elo0_wdata", csr_tlbelo0_wdata, (empty ? 32'h0 : e0));
            chk("elo1_wdata", csr_tlbelo1_wdata, (empty ? 32'h0 : e1));
            chk("asid_wdata", csr_asid_wdata, (empty ? 10'h0 : ard));
        end
        step();
        chk("done_pulse", done, 1'b0);
        chk("ready_after", op_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_kill = 1'b0; op_code = '0; inv_op_in = '0;
        inv_asid_in = '0; inv_vpn_in = '0; csr_tlbidx_in = '0;
        scramble_resp();
        repeat (3) step();
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_outs", {done, flush_req, ine_exc, tlbsrch_en, tlbwr_en, tlbfill_en, invtlb_en}, 7'b0);
        chk("rst_we", {csr_tlbidx_we, csr_tlbehi_we, csr_tlbelo0_we, csr_tlbelo1_we, csr_asid_we}, 5'b0);
        chk("rst_wdata", {csr_tlbidx_wdata, csr_tlbehi_wdata, csr_asid_wdata}, 74'h0);
        chk("rst_inv", {invtlb_op, invtlb_asid, invtlb_vpn}, 34'h0);
        chk("rst_rand", rand_index, exp_rand());
        rst_n = 1'b1;
        step();

        run_op(3'd0, 5'd0, 10'h0, 19'h0, 32'h0C00_0000, 1'b1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
        run_op(3'd0, 5'd0, 10'h0, 19'h0, 32'h0C00_0003, 1'b0, 5'd9, 0, 0, 0, 0, 0, 0, 0);
        run_op(3'd1, 5'd0, 10'h0, 19'h0, 32'h0C00_0004, 1'b0, 5'd0, 32'h1234_A000, 32'h11,
               32'h22, 32'h0C00_0004, 10'h05, 0, 0);
        run_op(3'd1, 5'd0, 10'h0, 19'h0, 32'h0C00_0011, 1'b0, 5'd0, 32'h1234_A000, 32'h11,
               32'h22, 32'h8000_0000, 10'h05, 0, 0);
        step(); step();
        run_op(3'd3, 5'd0, 10'h0, 19'h0, 32'h0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        run_op(3'd4, 5'd7, 10'h3, 19'h1, 32'h0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        run_op(3'd4, 5'd5, 10'h3, 19'h1, 32'h0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        run_op(3'd6, 5'd0, 10'h0, 19'h0, 32'h0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        run_op(3'd2, 5'd0, 10'h0, 19'h0, 32'h0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 1, 0);
        run_op(3'd2, 5'd0, 10'h0, 19'h0, 32'h0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0, 1);

        // Reset while the op sits in RESP
        op_valid = 1'b1; op_code = 3'd0; csr_tlbidx_in = 32'h0C00_0000;
        step();
        op_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_ready", op_ready, 1'b1);
        chk("rst_mid_outs", {done, flush_req, ine_exc, tlbsrch_en, csr_tlbidx_we}, 5'b0);
        chk("rst_mid_wdata", csr_tlbidx_wdata, 32'h0);
        chk("rst_mid_rand", rand_index, exp_rand());
        rst_n = 1'b1;
        step();
        chk("rst_mid_no_wb", done, 1'b0);

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 10'($urandom), 19'($urandom),
                   $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                   {1'($urandom), 31'($urandom)}, 10'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
